wallace_mac_pipe: RTL and testbench

//   Pipelined, parametrised Wallace-tree multiply-accumulate unit for the conv datapath.

---
 rtl/wallace_mac_pipe_if.sv | 33 +++
 rtl/wallace_mac_pipe.sv | 169 ++++++++++++++++
 tb/tb_wallace_mac_pipe.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/wallace_mac_pipe_if.sv
// Stream bundle for wallace_mac_pipe: input beat channel plus result channel.
//   in_valid/in_ready    input beat handshake
//   in_a/in_b            DWI-bit operands
//   in_signed            1: both operands two's complement, 0: both unsigned
//   in_first/in_last     accumulation group markers
//   out_valid/out_ready  result handshake
//   out_acc/out_ovf      accumulated group result and sticky group overflow
// master: beat producer / result consumer. slave: the MAC.
interface wallace_mac_pipe_if #(
  parameter int DWI  = 8,
  parameter int ACCW = 24
);
  logic            in_valid;
  logic            in_ready;
  logic [DWI-1:0]  in_a;
  logic [DWI-1:0]  in_b;
  logic            in_signed;
  logic            in_first;
  logic            in_last;
  logic            out_valid;
  logic            out_ready;
  logic [ACCW-1:0] out_acc;
  logic            out_ovf;

  modport master (
    output in_valid, in_a, in_b, in_signed, in_first, in_last, out_ready,
    input  in_ready, out_valid, out_acc, out_ovf
  );
  modport slave (
    input  in_valid, in_a, in_b, in_signed, in_first, in_last, out_ready,
    output in_ready, out_valid, out_acc, out_ovf
  );
endinterface

// File: rtl/wallace_mac_pipe.sv
// wallace_mac_pipe: 3-stage pipelined Wallace-tree multiply-accumulate.
//   S1: Baugh-Wooley partial products, CSA levels down to <=4 rows.
//   S2: CSA levels down to 2 rows.
//   S3: prefix-carry (CLA) final add, extend, accumulate, register result.
// Ports:
//   clk     rising-edge clock
//   rst_n   asynchronous active-low reset
//   io_mac  wallace_mac_pipe_if.slave (beat in, result out)
// Config macro: WALLACE_MAC_SAT_EN -- clamp accumulator on overflow
//   (default: wrap modulo 2^ACCW). out_ovf is reported either way.
module wallace_mac_pipe #(
  parameter int DWI  = 8,
  parameter int ACCW = 24
) (
  input  logic clk,
  input  logic rst_n,
  wallace_mac_pipe_if.slave io_mac
);
  localparam int PW = 2*DWI;
  localparam int NR = DWI + 1;       // DWI product rows + one Baugh-Wooley constant row
  localparam int IW = $clog2(NR);    // NR is odd, so IW also covers the value NR

  typedef logic [NR-1:0][PW-1:0] rows_t;
  typedef struct packed { logic sgn; logic first; logic last; } tag_t;

  // Carry-save reduce n0 rows until at most tgt remain. Row counts are
  // elaboration constants, so every level unrolls into plain 3:2 compressors.
  function automatic rows_t csa_reduce(input rows_t r, input int n0, input int tgt);
    rows_t cur, nxt;
    int n;
    logic [IW-1:0] m;
    cur = r;
    n   = n0;
    for (int lvl = 0; lvl < NR; lvl++) begin
      if (n > tgt) begin
        nxt = '0;
        m   = '0;
        for (int g = 0; g < NR/3; g++) begin
          if (3*g+2 < n) begin
            nxt[m] = cur[IW'(3*g)] ^ cur[IW'(3*g+1)] ^ cur[IW'(3*g+2)];
            m = m + 1'b1;
            nxt[m] = ((cur[IW'(3*g)]   & cur[IW'(3*g+1)]) |
                      (cur[IW'(3*g)]   & cur[IW'(3*g+2)]) |
                      (cur[IW'(3*g+1)] & cur[IW'(3*g+2)])) << 1;
            m = m + 1'b1;
          end
        end
        for (int k = 0; k < NR; k++) begin
          if (k >= 3*(n/3) && k < n) begin
            nxt[m] = cur[IW'(k)];
            m = m + 1'b1;
          end
        end
        cur = nxt;
        n   = int'(m);
      end
    end
    return cur;
  endfunction

  logic [3:1]           r_vld_pipe;
  tag_t                 r_tag1, r_tag2;
  logic [3:0][PW-1:0]   r_rows1;
  logic [1:0][PW-1:0]   r_rows2;
  logic [ACCW-1:0]      r_acc, r_out_acc;
  logic                 r_ovf, r_out_ovf;

  rows_t                w_pp, w_s2_in;
  logic [3:0][PW-1:0]   w_s1;
  logic [1:0][PW-1:0]   w_s2;
  logic [PW-1:0]        w_cg, w_cp, w_prod;
  logic [ACCW-1:0]      w_ext, w_acc_nxt;
  logic [ACCW:0]        w_sum;
  logic                 w_ovf_now, w_ovf_nxt, w_stall;

  // A pending, unaccepted result freezes the whole pipe including the accumulator.
  assign w_stall          = r_vld_pipe[3] & ~io_mac.out_ready;
  assign io_mac.in_ready  = ~w_stall;
  assign io_mac.out_valid = r_vld_pipe[3];
  assign io_mac.out_acc   = r_out_acc;
  assign io_mac.out_ovf   = r_out_ovf;

  // Baugh-Wooley: when signed, terms pairing exactly one operand MSB are
  // inverted and the constant 2^DWI + 2^(2DWI-1) is added (mod 2^(2DWI)).
  for (genvar gi = 0; gi < DWI; gi++) begin : g_pp
    localparam logic [DWI-1:0] MSK = (gi == DWI-1) ? ~(DWI'(1) << (DWI-1))
                                                   :  (DWI'(1) << (DWI-1));
    assign w_pp[gi] = PW'((io_mac.in_a & {DWI{io_mac.in_b[gi]}}) ^
                          (MSK & {DWI{io_mac.in_signed}})) << gi;
  end
  assign w_pp[DWI] = io_mac.in_signed ? ((PW'(1) << DWI) | (PW'(1) << (PW-1))) : '0;

  assign w_s1 = (4*PW)'(csa_reduce(w_pp, NR, 4));

  always_comb begin
    w_s2_in      = '0;
    w_s2_in[3:0] = r_rows1;
  end
  assign w_s2 = (2*PW)'(csa_reduce(w_s2_in, 4, 2));

  // Kogge-Stone prefix carries over the two remaining rows.
  always_comb begin
    w_cg = r_rows2[0] & r_rows2[1];
    w_cp = r_rows2[0] ^ r_rows2[1];
    for (int d = 1; d < PW; d = d*2) begin
      w_cg = w_cg | (w_cp & (w_cg << d));
      w_cp = w_cp & (w_cp << d);
    end
    w_prod = r_rows2[0] ^ r_rows2[1] ^ (w_cg << 1);
  end

  assign w_ext     = r_tag2.sgn ? ACCW'($signed(w_prod)) : ACCW'(w_prod);
  assign w_sum     = {1'b0, r_acc} + {1'b0, w_ext};
  assign w_ovf_now = r_tag2.sgn ? ((r_acc[ACCW-1] == w_ext[ACCW-1]) &&
                                   (w_sum[ACCW-1] != r_acc[ACCW-1]))
                                : w_sum[ACCW];

`ifdef WALLACE_MAC_SAT_EN
  localparam logic [ACCW-1:0] SMAX = {1'b0, {(ACCW-1){1'b1}}};
  localparam logic [ACCW-1:0] SMIN = {1'b1, {(ACCW-1){1'b0}}};
`endif

  always_comb begin
    w_acc_nxt = w_sum[ACCW-1:0];
    w_ovf_nxt = r_ovf | w_ovf_now;
    if (r_tag2.first) begin
      w_acc_nxt = w_ext;          // a lone product always fits
      w_ovf_nxt = 1'b0;
    end
`ifdef WALLACE_MAC_SAT_EN
    else if (r_ovf) begin
      w_acc_nxt = r_acc;          // stays clamped until the next first
    end else if (w_ovf_now) begin
      // Overflow only happens when both addends share the product's sign.
      w_acc_nxt = r_tag2.sgn ? (w_ext[ACCW-1] ? SMIN : SMAX) : '1;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_pipe <= '0;
      r_tag1     <= '0;
      r_tag2     <= '0;
      r_rows1    <= '0;
      r_rows2    <= '0;
      r_acc      <= '0;
      r_ovf      <= 1'b0;
      r_out_acc  <= '0;
      r_out_ovf  <= 1'b0;
    end else if (!w_stall) begin
      r_vld_pipe[1] <= io_mac.in_valid;
      r_tag1        <= '{sgn: io_mac.in_signed, first: io_mac.in_first, last: io_mac.in_last};
      r_rows1       <= w_s1;
      r_vld_pipe[2] <= r_vld_pipe[1];
      r_tag2        <= r_tag1;
      r_rows2       <= w_s2;
      r_vld_pipe[3] <= r_vld_pipe[2] & r_tag2.last;
      if (r_vld_pipe[2]) begin
        r_acc <= w_acc_nxt;
        r_ovf <= w_ovf_nxt;
        if (r_tag2.last) begin
          r_out_acc <= w_acc_nxt;
          r_out_ovf <= w_ovf_nxt;
        end
      end
    end
  end
endmodule

// File: tb/tb_wallace_mac_pipe.sv
module tb_wallace_mac_pipe;
  localparam int DWI  = 8;
  localparam int ACCW = 24;
  localparam longint SMAX = (longint'(1) << (ACCW-1)) - 1;
  localparam longint SMIN = -(longint'(1) << (ACCW-1));
  localparam longint UMAX = (longint'(1) << ACCW) - 1;

  typedef struct { logic [ACCW-1:0] acc; logic ovf; } res_t;

  logic clk = 1'b0;
  logic rst_n;
  logic rdy_rnd, rdy_frc;
  int   n_chk = 0;
  int   n_err = 0;
  res_t sb_q[$];
  res_t mon_r;
  logic [ACCW-1:0] m_acc;
  logic            m_ovf;

  always #5 clk = ~clk;

  wallace_mac_pipe_if #(.DWI(DWI), .ACCW(ACCW)) bus();
  wallace_mac_pipe #(.DWI(DWI), .ACCW(ACCW)) u_dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .io_mac (bus.slave)
  );

  always @(posedge clk) begin
    #1;
    bus.out_ready = rdy_rnd ? ($urandom_range(0, 3) != 0) : rdy_frc;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint prod(input logic [DWI-1:0] a, b, input logic s);
    longint x, y;
    x = s ? longint'($signed(a)) : longint'(a);
    y = s ? longint'($signed(b)) : longint'(b);
    return x * y;
  endfunction

  // Reference: exact integer sum, overflow if it leaves the ACCW range of the beat's type.
  task automatic mdl_beat(input logic [DWI-1:0] a, b, input logic s, f);
    longint p, cur, ex;
    logic   of;
    p = prod(a, b, s);
    if (f) begin
      m_acc = ACCW'(p);
      m_ovf = 1'b0;
    end else begin
      cur = s ? longint'($signed(m_acc)) : longint'(m_acc);
      ex  = cur + p;
      of  = s ? (ex > SMAX || ex < SMIN) : (ex > UMAX);
`ifdef WALLACE_MAC_SAT_EN
      if (!m_ovf) begin
        if (of) m_acc = s ? (ex > 0 ? ACCW'(SMAX) : ACCW'(SMIN)) : ACCW'(UMAX);
        else    m_acc = ACCW'(ex);
      end
`else
      m_acc = ACCW'(ex);
`endif
      m_ovf = m_ovf | of;
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      sb_q.delete();
      m_acc = '0;
      m_ovf = 1'b0;
    end else begin
      if (bus.out_valid && bus.out_ready) begin
        chk("sb_pending", sb_q.size() != 0, 1);
        if (sb_q.size() != 0) begin
          mon_r = sb_q.pop_front();
          chk("sb_acc", bus.out_acc, mon_r.acc);
          chk("sb_ovf", bus.out_ovf, mon_r.ovf);
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        mdl_beat(bus.in_a, bus.in_b, bus.in_signed, bus.in_first);
        if (bus.in_last) sb_q.push_back('{acc: m_acc, ovf: m_ovf});
      end
    end
  end

  task automatic send(input logic [DWI-1:0] a, b, input logic s, f, l);
    int t;
    bus.in_valid  = 1'b1;
    bus.in_a      = a;
    bus.in_b      = b;
    bus.in_signed = s;
    bus.in_first  = f;
    bus.in_last   = l;
    t = 0;
    @(negedge clk);
    while (!bus.in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!bus.in_ready) chk("in_ready_timeout", bus.in_ready, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_out();
    int t;
    t = 0;
    @(negedge clk);
    while (!bus.out_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("out_valid_seen", bus.out_valid, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [DWI-1:0] ra, rb;
    logic           rs, rf;
    int             len;
    rdy_rnd = 1'b0;
    rdy_frc = 1'b1;
    rst_n   = 1'b0;
    bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0;
    bus.in_signed = 1'b0; bus.in_first = 1'b0; bus.in_last = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_acc",   bus.out_acc,   0);
    chk("rst_out_ovf",   bus.out_ovf,   0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 1);
    @(posedge clk); #1;

    // unsigned 255*255, single-beat group, latency
    send(8'd255, 8'd255, 1'b0, 1'b1, 1'b1);
    idle();
    @(negedge clk); chk("lat_c1", bus.out_valid, 0);
    @(negedge clk); chk("lat_c2", bus.out_valid, 0);
    @(negedge clk); chk("lat_c3", bus.out_valid, 1);
    chk("u255_acc", bus.out_acc, 65025);
    chk("u255_ovf", bus.out_ovf, 0);
    @(posedge clk); #1;

    // signed -128*-128 + -128*127
    send(8'h80, 8'h80, 1'b1, 1'b1, 1'b0);
    send(8'h80, 8'h7f, 1'b1, 1'b0, 1'b1);
    idle();
    wait_out();
    chk("signed_acc", bus.out_acc, 128);
    @(posedge clk); #1;

    // 4-beat unsigned group back-to-back
    send(8'd1, 8'd2, 1'b0, 1'b1, 1'b0);
    send(8'd3, 8'd4, 1'b0, 1'b0, 1'b0);
    send(8'd5, 8'd6, 1'b0, 1'b0, 1'b0);
    send(8'd7, 8'd8, 1'b0, 1'b0, 1'b1);
    idle();
    wait_out();
    chk("grp4_acc", bus.out_acc, 100);
    @(posedge clk); #1;

    // backpressure: result held, next beat waits, nothing lost
    rdy_frc = 1'b0;
    @(posedge clk); #1;
    send(8'd2, 8'd3, 1'b0, 1'b1, 1'b1);
    idle();
    wait_out();
    bus.in_valid = 1'b1; bus.in_a = 8'd4; bus.in_b = 8'd5;
    bus.in_signed = 1'b0; bus.in_first = 1'b1; bus.in_last = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("stall_in_ready",  bus.in_ready,  0);
      chk("stall_out_valid", bus.out_valid, 1);
      chk("stall_out_acc",   bus.out_acc,   6);
    end
    rdy_frc = 1'b1;
    send(8'd4, 8'd5, 1'b0, 1'b1, 1'b1);
    idle();
    wait_out();
    chk("stall_next_acc", bus.out_acc, 20);
    @(posedge clk); #1;

    // signed 127*127 x 600 overflows a 24-bit accumulator
    for (int i = 0; i < 600; i++) send(8'd127, 8'd127, 1'b1, i == 0, i == 599);
    idle();
    wait_out();
    chk("ovf_flag", bus.out_ovf, 1);
`ifdef WALLACE_MAC_SAT_EN
    chk("ovf_acc", bus.out_acc, 8388607);
`else
    chk("ovf_acc", bus.out_acc, 9677400);   // -7099816 as a 24-bit pattern
`endif
    @(posedge clk); #1;

    // reset in the middle of a 3-beat group
    send(8'd3, 8'd4, 1'b0, 1'b1, 1'b0);
    send(8'd5, 8'd6, 1'b0, 1'b0, 1'b0);
    idle();
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", bus.out_valid, 0);
    chk("mid_rst_out_acc",   bus.out_acc,   0);
    chk("mid_rst_out_ovf",   bus.out_ovf,   0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send(8'd3, 8'd3, 1'b0, 1'b1, 1'b1);
    idle();
    wait_out();
    chk("post_rst_acc", bus.out_acc, 9);
    @(posedge clk); #1;

    // randomized groups, bubbles and backpressure against the scoreboard
    rdy_rnd = 1'b1;
    for (int g = 0; g < 60; g++) begin
      len = $urandom_range(1, 4);
      for (int k = 0; k < len; k++) begin
        if ($urandom_range(0, 3) == 0) begin
          idle();
          @(posedge clk); #1;
        end
        ra = DWI'($urandom);
        rb = DWI'($urandom);
        rs = 1'($urandom);
        rf = (k == 0) && ($urandom_range(0, 7) != 0);
        send(ra, rb, rs, rf, k == len-1);
      end
    end
    idle();
    rdy_rnd = 1'b0;
    rdy_frc = 1'b1;
    repeat (12) @(posedge clk);
    @(negedge clk);
    chk("sb_drained", sb_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
